// File: rtl/rgb_column_streamer_if.sv
// -----------------------------------------------------------------------------
// rgb_column_streamer_if
//   Bundles the pixel-in handshake and the column-out bus of the RGB column
//   streamer.
//   master : pixel source / column consumer (drives pix_*, observes the rest)
//   slave  : the streamer itself
//   Signals
//     pix_r/g/b   DATA_WIDTH    colour samples of the offered pixel
//     pix_sof     1             first pixel (0,0) of a frame
//     pix_valid   1             pixel offered
//     pix_ready   1             streamer can take a pixel
//     col_r/g/b   3*DATA_WIDTH  {row y-2, row y-1, row y}, MSB slice = top row
//     col_valid   1             one-cycle strobe per column
//     frame_done  1             one-cycle pulse after the last column
//     sync_err    1             sticky framing error flag
// -----------------------------------------------------------------------------
interface rgb_column_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   pix_r;
  logic [DATA_WIDTH-1:0]   pix_g;
  logic [DATA_WIDTH-1:0]   pix_b;
  logic                    pix_sof;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [3*DATA_WIDTH-1:0] col_r;
  logic [3*DATA_WIDTH-1:0] col_g;
  logic [3*DATA_WIDTH-1:0] col_b;
  logic                    col_valid;
  logic                    frame_done;
  logic                    sync_err;

  modport master (
    output pix_r, pix_g, pix_b, pix_sof, pix_valid,
    input  pix_ready, col_r, col_g, col_b, col_valid, frame_done, sync_err
  );

  modport slave (
    input  pix_r, pix_g, pix_b, pix_sof, pix_valid,
    output pix_ready, col_r, col_g, col_b, col_valid, frame_done, sync_err
  );
endinterface

// File: rtl/rgb_column_streamer.sv
// -----------------------------------------------------------------------------
// rgb_column_streamer
//   Turns a raster-order RGB pixel stream into 3-tall vertical columns per
//   channel for the first conv layer. Two line buffers hold the previous two
//   rows, so every pixel of rows 2..IMG_H-1 produces one column
//   {lb1[x], lb0[x], pix} one cycle after it is accepted.
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-low reset (0 = reset)
//     bus   rgb_column_streamer_if.slave: pixel handshake in, columns out,
//           frame_done pulse and sticky sync_err
// -----------------------------------------------------------------------------
module rgb_column_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 224,
  parameter int IMG_H      = 224
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb_column_streamer_if.slave  bus
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] b;
  } pix_t;

  state_t r_state;
  state_t w_next_state;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_wr_x;
  logic [YW-1:0] w_base_y;
  logic [XW-1:0] w_next_x;
  logic [YW-1:0] w_next_y;

  pix_t r_lb0 [IMG_W];
  pix_t r_lb1 [IMG_W];
  pix_t w_pix;
  pix_t w_lb0_rd;
  pix_t w_lb1_rd;

  logic w_accept;
  logic w_store;
  logic w_emit;
  logic w_err;

  logic                    r_ready;
  logic                    r_col_valid;
  logic                    r_frame_done;
  logic                    r_sync_err;
  logic [3*DATA_WIDTH-1:0] r_col_r;
  logic [3*DATA_WIDTH-1:0] r_col_g;
  logic [3*DATA_WIDTH-1:0] r_col_b;

  assign w_pix    = {bus.pix_r, bus.pix_g, bus.pix_b};
  assign w_accept = bus.pix_valid & r_ready;

  // Old-data reads: the column uses the buffers before this pixel's write.
  assign w_lb0_rd = r_lb0[r_x];
  assign w_lb1_rd = r_lb1[r_x];

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    w_next_state = r_state;
    w_store      = 1'b0;
    w_emit       = 1'b0;
    w_err        = 1'b0;
    w_wr_x       = r_x;
    w_base_y     = r_y;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.pix_sof) begin
            w_store      = 1'b1;
            w_wr_x       = '0;
            w_base_y     = '0;
            w_next_state = S_FILL;
          end else begin
            w_err = 1'b1;
          end
        end
      end

      S_FILL, S_STREAM: begin
        if (w_accept) begin
          w_store = 1'b1;
          if (bus.pix_sof) begin
            // Unexpected sof: this pixel becomes (0,0) of a fresh frame.
            w_err        = 1'b1;
            w_wr_x       = '0;
            w_base_y     = '0;
            w_next_state = S_FILL;
          end else begin
            w_emit = (r_state == S_STREAM);
            if (r_x == X_LAST) begin
              if (r_state == S_FILL && r_y == Y_ONE)
                w_next_state = S_STREAM;
              else if (r_state == S_STREAM && r_y == Y_LAST)
                w_next_state = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (w_wr_x == X_LAST) begin
      w_next_x = '0;
      w_next_y = w_base_y + 1'b1;
    end else begin
      w_next_x = w_wr_x + 1'b1;
      w_next_y = w_base_y;
    end

    // Park the counters at the origin once the frame is complete.
    if (w_next_state == S_DONE) begin
      w_next_x = '0;
      w_next_y = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // Counters and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_ready      <= 1'b0;
      r_col_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_col_r      <= '0;
      r_col_g      <= '0;
      r_col_b      <= '0;
    end else begin
      if (w_store) begin
        r_x <= w_next_x;
        r_y <= w_next_y;
      end
      r_ready      <= (w_next_state != S_DONE);
      r_col_valid  <= w_emit;
      // Pulses the cycle after DONE, i.e. one cycle after the last column.
      r_frame_done <= (r_state == S_DONE);
      if (w_err) r_sync_err <= 1'b1;
      if (w_emit) begin
        r_col_r <= {w_lb1_rd.r, w_lb0_rd.r, bus.pix_r};
        r_col_g <= {w_lb1_rd.g, w_lb0_rd.g, bus.pix_g};
        r_col_b <= {w_lb1_rd.b, w_lb0_rd.b, bus.pix_b};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb0 holds row y-1, lb1 holds row y-2 at each column.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the buffers are deliberately not reset; every entry is rewritten
    // during rows 0-1 before any column reads it, and leaving the reset off
    // lets the arrays map onto plain RAM.
    if (w_store) begin
      r_lb1[w_wr_x] <= r_lb0[w_wr_x];
      r_lb0[w_wr_x] <= w_pix;
    end
  end

  assign bus.pix_ready  = r_ready;
  assign bus.col_valid  = r_col_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.sync_err   = r_sync_err;
  assign bus.col_r      = r_col_r;
  assign bus.col_g      = r_col_g;
  assign bus.col_b      = r_col_b;

endmodule

// File: tb/tb_rgb_column_streamer.sv
// -----------------------------------------------------------------------------
// tb_rgb_column_streamer
//   Bench for rgb_column_streamer at IMG_W=IMG_H=4, DATA_WIDTH=8. Pixel (x,y)
//   carries r=16*y+x, g=r+0x40, b=r+0x80. A frame-level model keeps the
//   accepted image as a 2-D array and forms each column from rows y-2/y-1/y.
// -----------------------------------------------------------------------------
module tb_rgb_column_streamer;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  rgb_column_streamer_if #(.DATA_WIDTH(DW)) bus ();

  rgb_column_streamer #(
    .DATA_WIDTH(DW),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level model
  // ---------------------------------------------------------------------------
  logic [23:0] m_img [H][W];
  bit          m_active, m_in_done, m_ready, m_err, m_fd, m_cv, m_acc;
  int          mx, my;
  logic [23:0] m_pix;
  logic [23:0] m_col_r, m_col_g, m_col_b;
  logic [23:0] q_col_r[$];
  logic [23:0] q_col_g[$];
  logic [23:0] q_col_b[$];
  int          n_cols, n_fd;

  always @(posedge clk) begin
    if (!rst) begin
      m_active  = 0;
      m_in_done = 0;
      m_ready   = 0;
      m_err     = 0;
      m_fd      = 0;
      m_cv      = 0;
      mx        = 0;
      my        = 0;
      m_col_r   = '0;
      m_col_g   = '0;
      m_col_b   = '0;
    end else begin
      m_acc     = bus.pix_valid && m_ready;
      m_fd      = m_in_done;
      m_cv      = 0;
      m_in_done = 0;
      m_ready   = 1;
      if (m_acc) begin
        m_pix = {bus.pix_r, bus.pix_g, bus.pix_b};
        if (bus.pix_sof) begin
          if (m_active) m_err = 1;
          m_active     = 1;
          m_img[0][0]  = m_pix;
          mx           = 1;
          my           = 0;
        end else if (!m_active) begin
          m_err = 1;
        end else begin
          if (my >= 2) begin
            m_cv    = 1;
            m_col_r = {m_img[my-2][mx][23:16], m_img[my-1][mx][23:16], bus.pix_r};
            m_col_g = {m_img[my-2][mx][15:8],  m_img[my-1][mx][15:8],  bus.pix_g};
            m_col_b = {m_img[my-2][mx][7:0],   m_img[my-1][mx][7:0],   bus.pix_b};
            q_col_r.push_back(m_col_r);
            q_col_g.push_back(m_col_g);
            q_col_b.push_back(m_col_b);
          end
          m_img[my][mx] = m_pix;
          if (mx == W - 1) begin
            mx = 0;
            if (my == H - 1) begin
              m_active  = 0;
              m_in_done = 1;
              m_ready   = 0;
            end else begin
              my++;
            end
          end else begin
            mx++;
          end
        end
      end
    end

    // Compare away from the edge.
    #1;
    check("col_valid",  bus.col_valid,  m_cv);
    check("frame_done", bus.frame_done, m_fd);
    check("sync_err",   bus.sync_err,   m_err);
    check("pix_ready",  bus.pix_ready,  m_ready);
    check("col_r",      bus.col_r,      m_col_r);
    check("col_g",      bus.col_g,      m_col_g);
    check("col_b",      bus.col_b,      m_col_b);
    if (bus.col_valid)  n_cols++;
    if (bus.frame_done) n_fd++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
    end
  endtask

  task automatic send_px(input int x, input int y, input bit sof);
    int waited;
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_r     = 8'(16 * y + x);
    bus.pix_g     = 8'(16 * y + x + 8'h40);
    bus.pix_b     = 8'(16 * y + x + 8'h80);
    waited = 0;
    while (!bus.pix_ready) begin
      if (waited == 50) begin
        n_vec++;
        n_err++;
        $display("FAIL handshake: pix_ready stayed %b for 50 cycles, required 1", bus.pix_ready);
        break;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic send_frame(input int gap_max);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (gap_max > 0) drive_idle($urandom_range(0, gap_max));
        send_px(x, y, (x == 0) && (y == 0));
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    rst           = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_counts();
    n_cols = 0;
    n_fd   = 0;
    q_col_r.delete();
    q_col_g.delete();
    q_col_b.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  logic [23:0] ref_r[$];
  logic [23:0] ref_g[$];
  logic [23:0] ref_b[$];

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_r     = '0;
    bus.pix_g     = '0;
    bus.pix_b     = '0;
    n_cols        = 0;
    n_fd          = 0;

    // 1. Reset behaviour
    repeat (2) @(negedge clk);
    check("t1 reset pix_ready",  bus.pix_ready,  1'b0);
    check("t1 reset col_valid",  bus.col_valid,  1'b0);
    check("t1 reset frame_done", bus.frame_done, 1'b0);
    check("t1 reset sync_err",   bus.sync_err,   1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t1 ready after reset", bus.pix_ready, 1'b1);

    // 2. Full frame, one pixel per cycle
    clear_counts();
    send_frame(0);
    drive_idle(4);
    check("t2 columns",      n_cols, 8);
    check("t2 frame_done",   n_fd, 1);
    check("t2 sync_err",     bus.sync_err, 1'b0);
    check("t2 model count",  q_col_r.size(), 8);
    // Column 1 of row 2: rows 0,1,2 at x=1.
    check("t2 model col1 r", q_col_r[1], 24'h011121);
    check("t2 model col1 b", q_col_b[1], 24'h8191A1);
    check("t2 model last r", q_col_r[7], 24'h132333);
    check("t2 model last g", q_col_g[7], 24'h536373);
    ref_r = q_col_r;
    ref_g = q_col_g;
    ref_b = q_col_b;

    // 3. Same frame with random valid gaps
    clear_counts();
    send_frame(2);
    drive_idle(4);
    check("t3 columns",    n_cols, 8);
    check("t3 frame_done", n_fd, 1);
    for (int i = 0; i < 8; i++) begin
      check("t3 col_r order", q_col_r[i], ref_r[i]);
      check("t3 col_g order", q_col_g[i], ref_g[i]);
      check("t3 col_b order", q_col_b[i], ref_b[i]);
    end

    // 4. Pixels without sof while idle
    do_reset();
    clear_counts();
    send_px(0, 1, 1'b0);
    send_px(1, 1, 1'b0);
    send_px(2, 1, 1'b0);
    drive_idle(3);
    check("t4 no columns", n_cols, 0);
    check("t4 sync_err",   bus.sync_err, 1'b1);
    send_frame(0);
    drive_idle(4);
    check("t4 columns after", n_cols, 8);
    check("t4 sync_err held", bus.sync_err, 1'b1);

    // 5. sof arriving mid row 2 restarts the frame
    do_reset();
    clear_counts();
    for (int i = 0; i < 2 * W + 2; i++)
      send_px(i % W, i / W, i == 0);
    drive_idle(2);
    check("t5 partial columns", n_cols, 2);
    check("t5 no err before",   bus.sync_err, 1'b0);
    clear_counts();
    send_frame(0);
    drive_idle(4);
    check("t5 columns",      n_cols, 8);
    check("t5 frame_done",   n_fd, 1);
    check("t5 sync_err",     bus.sync_err, 1'b1);
    check("t5 model first r", q_col_r[0], 24'h001020);
    check("t5 model last r",  q_col_r[7], 24'h132333);

    // 6. Reset during row 3, then a clean frame
    clear_counts();
    for (int i = 0; i < 3 * W + 2; i++)
      send_px(i % W, i / W, i == 0);
    do_reset();
    clear_counts();
    drive_idle(3);
    check("t6 no stale column", n_cols, 0);
    check("t6 no stale done",   n_fd, 0);
    send_frame(0);
    drive_idle(4);
    check("t6 columns",    n_cols, 8);
    check("t6 frame_done", n_fd, 1);
    check("t6 sync_err",   bus.sync_err, 1'b0);
    for (int i = 0; i < 8; i++)
      check("t6 col_r", q_col_r[i], ref_r[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
